// File: rtl/wishbone_board_ram_if.sv
// Pipelined Wishbone bus bundle shared by the arbiter (master side) and the board RAM (slave side).
// Signal suffixes are named from the master's point of view.
interface wishbone_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  we_o;
  logic                  stb_o;
  logic                  cyc_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic                  ack_i;
  logic                  stall_i;

  modport master (
    output adr_o, dat_o, we_o, stb_o, cyc_o,
    input  dat_i, ack_i, stall_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, stb_o, cyc_o,
    output dat_i, ack_i, stall_i
  );
endinterface

// File: rtl/wishbone_board_ram.sv
// Minesweeper board RAM: pipelined Wishbone slave with a hardware clear sweep after reset/on request.
// Define WB_BOARD_RAM_OUTREG_EN to add a registered dat_i/ack_i stage (ack latency 2 instead of 1).
module wishbone_board_ram #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_req,
  output logic       init_busy,
  wishbone_if.slave  bus
);

  localparam int unsigned           CntW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DepthLim = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CntW-1:0]       LastIdx  = CntW'(DEPTH - 1);

  typedef enum logic [1:0] {StSweep, StDrain, StReady} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  stall_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  in_range;
  logic [CntW-1:0]       idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  pipe_busy;

  logic                  mem_we;
  logic [CntW-1:0]       mem_idx;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  ack_a_q;
  logic [DATA_WIDTH-1:0] dat_a_q;

  assign accept   = bus.cyc_o & bus.stb_o & ~stall_q;
  assign in_range = {1'b0, bus.adr_o} < DepthLim;
  assign idx      = bus.adr_o[CntW-1:0];
  assign rd_word  = (in_range && !bus.we_o) ? mem[idx] : '0;

  // Memory port: the sweep owns it whenever it runs; bus writes only land in READY.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = idx;
    mem_wdata = bus.dat_o;
    if (state_q == StSweep) begin
      mem_we    = 1'b1;
      mem_idx   = cnt_q;
      mem_wdata = INIT_VALUE;
    end else if (accept && bus.we_o && in_range) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  // First response stage; read data is captured from the pre-edge contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_a_q <= 1'b0;
      dat_a_q <= '0;
    end else begin
      ack_a_q <= accept;
      dat_a_q <= accept ? rd_word : '0;
    end
  end

`ifdef WB_BOARD_RAM_OUTREG_EN
  logic                  ack_b_q;
  logic [DATA_WIDTH-1:0] dat_b_q;

  // A cycle drop flushes the request that has not yet reached the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_b_q <= 1'b0;
      dat_b_q <= '0;
    end else begin
      ack_b_q <= ack_a_q & bus.cyc_o;
      dat_b_q <= (ack_a_q && bus.cyc_o) ? dat_a_q : '0;
    end
  end

  assign pipe_busy = ack_a_q & bus.cyc_o;
  assign bus.ack_i = ack_b_q;
  assign bus.dat_i = dat_b_q;
`else
  assign pipe_busy = 1'b0;
  assign bus.ack_i = ack_a_q;
  assign bus.dat_i = dat_a_q;
`endif

  // pipe_busy marks a request that still needs another cycle before its ack is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StSweep;
      cnt_q   <= '0;
      stall_q <= 1'b1;
    end else begin
      unique case (state_q)
        StSweep: begin
          if (clear_req) begin
            cnt_q <= '0;
          end else if (cnt_q == LastIdx) begin
            cnt_q   <= '0;
            state_q <= StReady;
            stall_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDrain: begin
          if (!pipe_busy) begin
            state_q <= StSweep;
            cnt_q   <= '0;
          end
        end
        StReady: begin
          if (clear_req) begin
            stall_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= (accept || pipe_busy) ? StDrain : StSweep;
          end
        end
        default: begin
          state_q <= StSweep;
          cnt_q   <= '0;
          stall_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.stall_i = stall_q;
  assign init_busy   = stall_q;

endmodule
